rom_loader: RTL and testbench
=============================

ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter ADDR_W, default 24: byte-address width of the ROM store.
REQ-002 Parameter HDR_BYTES, default 512: copier-header size in bytes.
REQ-003 clk_sys  in  1  system clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ioctl_download  in  1  high for the duration of a ROM transfer.
REQ-006 ioctl_wr  in  1  one-cycle strobe marking a valid 16-bit word.
REQ-007 ioctl_addr  in  25  byte address of the word, always even.
REQ-008 ioctl_dout  in  16  ROM word, little-endian.
REQ-009 ioctl_wait  out  1  stall to the HPS side.
REQ-010 swap_en  in  1  runtime request to bit-reverse each byte.
REQ-011 wr_addr  out  ADDR_W  byte address sent to the DDRAM writer.
REQ-012 wr_data  out  16  word sent to the DDRAM writer.
REQ-013 wr_req  out  1  toggle request to the DDRAM writer.
REQ-014 wr_ack  in  1  toggle acknowledge from the DDRAM writer.
REQ-015 rd_offset  out  ADDR_W  header skip to be added to read addresses.
REQ-016 rom_sz  out  8  ROM size in 64 KiB units, header excluded.
REQ-017 load_done  out  1  one-cycle pulse when a load completes.
REQ-018 overrun  out  1  sticky protocol-error flag.

Function
REQ-019 FSM states are IDLE, ARMED, ISSUE, WAIT_ACK and FINISH.
REQ-020 IDLE→ARMED on the rising edge of ioctl_download; on that edge wr_req←wr_ack, byte_cnt←0, overrun←0 and rd_offset is held.
REQ-021 ARMED, on ioctl_wr: latch ioctl_addr[ADDR_W-1:0] and the (optionally swapped) data; set ioctl_wait=1 on the next cycle; go to ISSUE.
REQ-022 ISSUE: toggle wr_req once, then go to WAIT_ACK; wr_addr and wr_data stay stable until the acknowledge.
REQ-023 WAIT_ACK: when wr_ack==wr_req, clear ioctl_wait next cycle, set byte_cnt←max(byte_cnt, latched_addr+2), and return to ARMED.
REQ-024 Latency from ioctl_wr to the wr_req toggle is exactly 2 cycles.
REQ-025 ioctl_wr in ISSUE or WAIT_ACK sets overrun, is dropped, and leaves the FSM unchanged.
REQ-026 A falling edge of ioctl_download in ARMED goes to FINISH.
REQ-027 A falling edge in ISSUE or WAIT_ACK first completes the pending write, then goes to FINISH.
REQ-028 FINISH, for one cycle:
- If byte_cnt mod 8192 == HDR_BYTES: rd_offset←HDR_BYTES, size←byte_cnt−HDR_BYTES.
- Otherwise: rd_offset←0, size←byte_cnt.
- rom_sz←size[23:16]; load_done=1; then go to IDLE.
REQ-029 byte_cnt is ADDR_W+1 bits and saturates at all-ones; addresses at or above 2^ADDR_W set overrun and are not written.
REQ-030 A new rising edge of ioctl_download in any state restarts at ARMED; a pending ack is abandoned by resyncing wr_req←wr_ack.
REQ-031 A download of zero words gives rom_sz=0 and rd_offset=0, and load_done still pulses.

Reset
REQ-032 reset_n low sets, asynchronously: state IDLE, ioctl_wait 0, wr_req 0, wr_addr 0, wr_data 0, rd_offset 0, rom_sz 0, load_done 0, overrun 0, byte_cnt 0.
REQ-033 Reset asserted mid-transfer abandons the word in flight; the DDRAM writer is reset by the same reset_n, so both toggles restart at 0.

Configuration
REQ-034 Macro ROM_LOADER_BITSWAP_EN defined: when swap_en=1, each byte of ioctl_dout is bit-reversed (bit i↔7−i) before it is latched; when swap_en=0, data passes unchanged.
REQ-035 Macro ROM_LOADER_BITSWAP_EN undefined: swap_en is ignored and data always passes unchanged.

Structure
REQ-036 Package rom_loader_pkg holds the FSM state enum, HDR_BYTES_DEF=512, and BANK_BYTES=8192.
REQ-037 Sub-module rom_byte_swap is the combinational 16-bit per-byte bit-reverser; it is instantiated only under ROM_LOADER_BITSWAP_EN.

Verification
REQ-038 Download 4 words (addr 0..6), wr_ack echoing 3 cycles after each toggle → 4 writes; ioctl_wait high per word; rom_sz=0; rd_offset=0; load_done pulses once.
REQ-039 Download 8192+512 bytes → rd_offset=0x200; size 8192; rom_sz=0.
REQ-040 Download 0x60000 bytes → rom_sz=0x06; rd_offset=0.
REQ-041 With ROM_LOADER_BITSWAP_EN and swap_en=1, ioctl_dout=0x0180 → wr_data=0x8001.
REQ-042 ioctl_wr pulsed during WAIT_ACK → overrun=1; write count unchanged.
REQ-043 reset_n pulsed low during WAIT_ACK → all outputs at reset values immediately; the next download completes normally.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM loader: FSM state encoding and
// copier-header / bank geometry used to detect a header on the loaded image.
package rom_loader_pkg;

  localparam int HDR_BYTES_DEF = 512;
  localparam int BANK_BYTES    = 8192;
  localparam int BANK_BITS     = $clog2(BANK_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    ISSUE,
    WAIT_ACK,
    FINISH
  } state_t;

endpackage

// File: rtl/rom_byte_swap.sv
// Combinational per-byte bit reverser for 16-bit ROM words (bit i <-> 7-i in
// each byte). Only instantiated when ROM_LOADER_BITSWAP_EN is defined.
module rom_byte_swap (
  input  logic [15:0] raw,
  output logic [15:0] rev
);

  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    rev = '0;
    for (int i = 0; i < 8; i++) begin
      rev[i]     = raw[7 - i];
      rev[8 + i] = raw[15 - i];
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Streams HPS ioctl ROM words into a toggle-handshake DDRAM writer, tracks the
// image size and detects a copier header. Build option: ROM_LOADER_BITSWAP_EN.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int HDR_BYTES = HDR_BYTES_DEF
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [15:0]       ioctl_dout,
  output logic              ioctl_wait,
  input  logic              swap_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [ADDR_W-1:0] rd_offset,
  output logic [7:0]        rom_sz,
  output logic              load_done,
  output logic              overrun
);

  localparam int CNT_W = ADDR_W + 1;

  state_t            state_q, state_d;
  logic              dl_q;
  logic              fin_pend_q;
  logic [CNT_W-1:0]  byte_cnt_q;
  logic [15:0]       data_sel;

  logic              dl_rise, dl_fall, addr_oor, ack_match, hdr_hit;
  logic [ADDR_W+1:0] end_sum;
  logic [CNT_W-1:0]  end_sat, cnt_next, size_c;

`ifdef ROM_LOADER_BITSWAP_EN
  logic [15:0] dout_rev;

  rom_byte_swap u_swap (
    .raw (ioctl_dout),
    .rev (dout_rev)
  );

  assign data_sel = swap_en ? dout_rev : ioctl_dout;
`else
  logic unused_swap_en;

  assign unused_swap_en = swap_en;
  assign data_sel       = ioctl_dout;
`endif

  assign dl_rise   = ioctl_download & ~dl_q;
  assign dl_fall   = ~ioctl_download & dl_q;
  assign addr_oor  = (ioctl_addr >> ADDR_W) != '0;
  assign ack_match = (wr_ack == wr_req);

  // End address of the acknowledged word, clamped to the counter range.
  assign end_sum  = {2'b00, wr_addr} + (ADDR_W + 2)'(2);
  assign end_sat  = end_sum[ADDR_W+1] ? '1 : end_sum[CNT_W-1:0];
  assign cnt_next = (end_sat > byte_cnt_q) ? end_sat : byte_cnt_q;

  assign hdr_hit = byte_cnt_q[BANK_BITS-1:0] == BANK_BITS'(HDR_BYTES);
  assign size_c  = hdr_hit ? byte_cnt_q - CNT_W'(HDR_BYTES) : byte_cnt_q;

  always_comb begin
    state_d = state_q;
    if (dl_rise) begin
      state_d = ARMED;
    end else begin
      unique case (state_q)
        IDLE:     state_d = IDLE;
        ARMED:    if (dl_fall)                 state_d = FINISH;
                  else if (ioctl_wr && !addr_oor) state_d = ISSUE;
        ISSUE:    state_d = WAIT_ACK;
        WAIT_ACK: if (ack_match) state_d = (fin_pend_q || dl_fall) ? FINISH : ARMED;
        FINISH:   state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      dl_q       <= 1'b0;
      fin_pend_q <= 1'b0;
      byte_cnt_q <= '0;
      ioctl_wait <= 1'b0;
      wr_req     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rd_offset  <= '0;
      rom_sz     <= '0;
      load_done  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dl_q      <= ioctl_download;
      load_done <= 1'b0;
      if (dl_rise) begin
        // Abandon any in-flight word by resyncing the toggle pair.
        wr_req     <= wr_ack;
        byte_cnt_q <= '0;
        overrun    <= 1'b0;
        ioctl_wait <= 1'b0;
        fin_pend_q <= 1'b0;
      end else begin
        unique case (state_q)
          ARMED: begin
            if (ioctl_wr && !dl_fall) begin
              if (addr_oor) begin
                overrun <= 1'b1;
              end else begin
                wr_addr    <= ioctl_addr[ADDR_W-1:0];
                wr_data    <= data_sel;
                ioctl_wait <= 1'b1;
              end
            end
          end
          ISSUE, WAIT_ACK: begin
            if (state_q == ISSUE) wr_req <= ~wr_req;
            if (ioctl_wr)         overrun <= 1'b1;
            if (dl_fall)          fin_pend_q <= 1'b1;
            if (state_q == WAIT_ACK && ack_match) begin
              ioctl_wait <= 1'b0;
              byte_cnt_q <= cnt_next;
            end
          end
          FINISH: begin
            rd_offset  <= hdr_hit ? ADDR_W'(HDR_BYTES) : '0;
            rom_sz     <= size_c[23:16];
            load_done  <= 1'b1;
            fin_pend_q <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: directed scenarios plus randomized
// downloads, checked against an image-level model of writes and size rules.
module tb_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic        ioctl_wait;
  logic        swap_en = 1'b0;
  logic [23:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_req;
  logic        wr_ack;
  logic [23:0] rd_offset;
  logic [7:0]  rom_sz;
  logic        load_done;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;

  rom_loader dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .swap_en        (swap_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_req         (wr_req),
    .wr_ack         (wr_ack),
    .rd_offset      (rd_offset),
    .rom_sz         (rom_sz),
    .load_done      (load_done),
    .overrun        (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  // DDRAM writer model: capture each request toggle, echo it after ack_dly cycles.
  logic [23:0] got_addr[$];
  logic [15:0] got_data[$];
  int          ack_dly = 3;
  int          ack_timer;
  logic        req_q;

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ack    <= 1'b0;
      req_q     <= 1'b0;
      ack_timer <= 0;
    end else begin
      req_q <= wr_req;
      if (wr_req != req_q) begin
        got_addr.push_back(wr_addr);
        got_data.push_back(wr_data);
        ack_timer <= ack_dly;
      end else if (ack_timer == 1) begin
        wr_ack    <= ~wr_ack;
        ack_timer <= 0;
      end else if (ack_timer != 0) begin
        ack_timer <= ack_timer - 1;
      end
    end
  end

  int done_cnt = 0;
  always @(negedge clk_sys) if (load_done === 1'b1) done_cnt++;

  // Reference model state for the current download.
  logic [23:0] exp_addr[$];
  logic [15:0] exp_data[$];
  longint      cnt_m;
  bit          ov_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_data(input logic [15:0] d, input logic sw);
    logic [7:0] lo, hi;
    lo = d[7:0];
    hi = d[15:8];
`ifdef ROM_LOADER_BITSWAP_EN
    if (sw) begin
      lo = {<<{lo}};
      hi = {<<{hi}};
    end
`endif
    return {hi, lo};
  endfunction

  task automatic start_dl();
    got_addr.delete();
    got_data.delete();
    exp_addr.delete();
    exp_data.delete();
    cnt_m    = 0;
    ov_exp   = 1'b0;
    done_cnt = 0;
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    check("overrun_cleared", overrun, 0);
  endtask

  // One HPS word; inject pulses ioctl_wr during WAIT_ACK, drop ends the download there.
  task automatic send_word(input logic [24:0] addr, input logic [15:0] data,
                           input bit inject, input bit drop);
    logic req0, req_tgl;
    int   n;
    @(negedge clk_sys);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    req0       = wr_req;
    req_tgl    = ~req0;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    if (addr >= 25'h1000000) begin
      ov_exp = 1'b1;
      check("oor_no_wait", ioctl_wait, 0);
    end else begin
      exp_addr.push_back(addr[23:0]);
      exp_data.push_back(model_data(data, swap_en));
      if (longint'(addr) + 2 > cnt_m) cnt_m = longint'(addr) + 2;
      check("wait_set", ioctl_wait, 1);
      check("req_not_yet", wr_req, req0);
      @(negedge clk_sys);
      check("req_toggle_2cyc", wr_req, req_tgl);
      if (drop) ioctl_download = 1'b0;
      if (inject) begin
        ioctl_wr   = 1'b1;
        ioctl_addr = addr ^ 25'h4;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        ov_exp   = 1'b1;
      end
      n = 0;
      while (ioctl_wait === 1'b1 && n < 40) begin
        @(negedge clk_sys);
        n++;
      end
      check("wait_cleared", ioctl_wait, 0);
    end
  endtask

  task automatic end_dl();
    int     n;
    longint sz;
    longint off;
    if (ioctl_download) begin
      @(negedge clk_sys);
      ioctl_download = 1'b0;
    end
    n = 0;
    while (done_cnt == 0 && n < 20) begin
      @(negedge clk_sys);
      n++;
    end
    repeat (3) @(negedge clk_sys);
    if (cnt_m % 8192 == 512) begin
      off = 512;
      sz  = cnt_m - 512;
    end else begin
      off = 0;
      sz  = cnt_m;
    end
    check("load_done_once", done_cnt, 1);
    check("rom_sz", rom_sz, 32'((sz / 65536) % 256));
    check("rd_offset", rd_offset, 32'(off));
    check("overrun", overrun, 32'(ov_exp));
    check("write_count", got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i < got_addr.size()) begin
        check("wr_addr", got_addr[i], exp_addr[i]);
        check("wr_data", got_data[i], exp_data[i]);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wait"},      ioctl_wait, 0);
    check({tag, "_wr_req"},    wr_req, 0);
    check({tag, "_wr_addr"},   wr_addr, 0);
    check({tag, "_wr_data"},   wr_data, 0);
    check({tag, "_rd_offset"}, rd_offset, 0);
    check({tag, "_rom_sz"},    rom_sz, 0);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_overrun"},   overrun, 0);
  endtask

  initial begin
    // Reset values.
    repeat (3) @(negedge clk_sys);
    check_reset_outputs("rst");
    reset_n = 1'b1;

    // Four consecutive words, ack after 3 cycles.
    ack_dly = 3;
    start_dl();
    for (int i = 0; i < 4; i++) send_word(25'(2 * i), 16'($urandom), 1'b0, 1'b0);
    end_dl();
    check("four_rom_sz", rom_sz, 0);

    // 8192 + 512 bytes: header detected.
    start_dl();
    send_word(25'h0, 16'($urandom), 1'b0, 1'b0);
    send_word(25'({$urandom_range(1, 4000), 1'b0}), 16'($urandom), 1'b0, 1'b0);
    send_word(25'h21FE, 16'($urandom), 1'b0, 1'b0);
    end_dl();
    check("hdr_rd_offset", rd_offset, 24'h200);

    // Zero words clears a previous header offset.
    start_dl();
    end_dl();
    check("zero_rd_offset", rd_offset, 0);

    // 0x60000 bytes.
    start_dl();
    send_word(25'({$urandom_range(0, 16'hFFFF), 1'b0}), 16'($urandom), 1'b0, 1'b0);
    send_word(25'h5FFFE, 16'($urandom), 1'b0, 1'b0);
    end_dl();
    check("size_6_rom_sz", rom_sz, 8'h06);

    // Download ends while the write is pending; it still completes.
    ack_dly = 4;
    start_dl();
    send_word(25'h100, 16'($urandom), 1'b0, 1'b0);
    send_word(25'h1FFFE, 16'($urandom), 1'b0, 1'b1);
    end_dl();
    check("drop_rom_sz", rom_sz, 8'h02);

    // ioctl_wr during WAIT_ACK, then an out-of-range address.
    ack_dly = 3;
    start_dl();
    send_word(25'h40, 16'hA5A5, 1'b1, 1'b0);
    check("inject_overrun", overrun, 1);
    send_word(25'h42, 16'h5A5A, 1'b0, 1'b0);
    end_dl();
    start_dl();
    send_word(25'h1000010, 16'h1234, 1'b0, 1'b0);
    check("oor_overrun", overrun, 1);
    send_word(25'h10, 16'h4321, 1'b0, 1'b0);
    end_dl();

`ifdef ROM_LOADER_BITSWAP_EN
    swap_en = 1'b1;
    start_dl();
    send_word(25'h0, 16'h0180, 1'b0, 1'b0);
    end_dl();
    check("swap_0180", got_data[0], 16'h8001);
    swap_en = 1'b0;
`endif

    // Reset asserted during WAIT_ACK.
    start_dl();
    @(negedge clk_sys);
    ioctl_addr = 25'h123456;
    ioctl_dout = 16'hBEEF;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk_sys);
    reset_n = 1'b1;

    // Randomized downloads.
    for (int t = 0; t < 8; t++) begin
      int          nw;
      logic [24:0] a;
      swap_en = 1'($urandom);
      ack_dly = $urandom_range(1, 4);
      nw      = $urandom_range(1, 8);
      start_dl();
      for (int i = 0; i < nw; i++) begin
        a = 25'({$urandom_range(0, 20'h3FFFF), 1'b0});
        if ($urandom_range(0, 7) == 0) a = a | 25'h1000000;
        send_word(a, 16'($urandom), 1'($urandom_range(0, 9) == 0), 1'b0);
      end
      if (t % 2 == 1) send_word(25'(8192 * $urandom_range(40, 60) + 510), 16'($urandom), 1'b0, 1'b0);
      end_dl();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
